// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART byte/word adaptation stage.
// Build option: UART_CTRL_MSB_FIRST_EN selects big-endian byte order on both
// the RX packer and the TX serialiser (default little-endian).
package uart_ctrl_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} tx_state_t;

  // Maps the byte sequence index (0 = first on the wire) to a word lane.
  function automatic logic [1:0] lane_sel(input logic [1:0] idx);
`ifdef UART_CTRL_MSB_FIRST_EN
    return ~idx;
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// TX serialiser: latches a 32-bit word from the bridge and presents it as four
// bytes over a valid/ready handshake. Also owns the sticky overrun flag.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   data_in, data_in_en  word from bridge and its one-cycle strobe
//   err_clr              synchronous clear of err_overrun
//   tx_byte, tx_byte_vld byte to transmitter, held until accepted
//   tx_byte_rdy          transmitter ready
//   tx_busy              serialiser not idle
//   err_overrun          sticky: word arrived while busy and was dropped
// Build option: UART_CTRL_MSB_FIRST_EN (lane order via lane_sel).
module uart_tx_serializer
  import uart_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_in_en,
  input  logic              err_clr,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              tx_byte_vld,
  input  logic              tx_byte_rdy,
  output logic              tx_busy,
  output logic              err_overrun
);

  tx_state_t         state_q, state_d;
  logic [WORD_W-1:0] tx_buf_q, tx_buf_d;
  logic [1:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
  logic [1:0]        idx_nxt;

  function automatic logic [BYTE_W-1:0] pick(input logic [WORD_W-1:0] w,
                                             input logic [1:0] idx);
    return w[{lane_sel(idx), 3'b000} +: BYTE_W];
  endfunction

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    tx_buf_d = tx_buf_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    vld_d    = vld_q;
    ovr_d    = ovr_q;
    idx_nxt  = idx_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (data_in_en) begin
          tx_buf_d = data_in;
          idx_d    = 2'd0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        byte_d  = pick(tx_buf_q, idx_q);
        vld_d   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (vld_q && tx_byte_rdy) begin
          if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
            vld_d   = 1'b0;
            state_d = DONE;
          end else begin
            idx_d  = idx_nxt;
            byte_d = pick(tx_buf_q, idx_nxt);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new set outranks a same-cycle clear
    if (data_in_en && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end else if (err_clr) begin
      ovr_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tx_buf_q <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_buf_q <= tx_buf_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  assign tx_byte     = byte_q;
  assign tx_byte_vld = vld_q;
  assign tx_busy     = busy_q;
  assign err_overrun = ovr_q;

endmodule

// File: rtl/uart_ctrl.sv
// UART byte-to-word adaptation stage between the byte PHY and the bus bridge.
// RX: packs four bytes into a word, pulses UcUb_data_out_en for one cycle;
// partially assembled words are discarded after TIMEOUT_CYC idle clocks.
// TX: serialises a word from the bridge as four bytes (uart_tx_serializer).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   rx_byte, rx_byte_vld               byte from receiver and its strobe
//   tx_byte, tx_byte_vld, tx_byte_rdy  byte handshake to transmitter
//   UcUb_data_out, UcUb_data_out_en    assembled RX word to bridge
//   UbUc_data_in, UbUc_data_in_en      read-back word from bridge
//   tx_busy                            TX serialiser not idle
//   err_timeout, err_overrun, err_clr  sticky flags and their clear
// Build option: UART_CTRL_MSB_FIRST_EN selects big-endian byte order.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned TO_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic              rx_byte_vld,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              tx_byte_vld,
  input  logic              tx_byte_rdy,
  output logic [WORD_W-1:0] UcUb_data_out,
  output logic              UcUb_data_out_en,
  input  logic [WORD_W-1:0] UbUc_data_in,
  input  logic              UbUc_data_in_en,
  output logic              tx_busy,
  output logic              err_timeout,
  output logic              err_overrun,
  input  logic              err_clr
);

  logic [1:0]        rx_cnt_q, rx_cnt_d;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [TO_W-1:0]   to_inc;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              out_en_q, out_en_d;
  logic              err_to_q, err_to_d;
  logic [WORD_W-1:0] word_c;

  // RX packing and inter-byte timeout
  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    shadow_d   = shadow_q;
    to_cnt_d   = to_cnt_q;
    data_out_d = data_out_q;
    out_en_d   = 1'b0;
    err_to_d   = err_to_q;
    to_inc     = to_cnt_q + TO_W'(1);
    word_c     = shadow_q;
    word_c[{lane_sel(rx_cnt_q), 3'b000} +: BYTE_W] = rx_byte;

    if (err_clr) begin
      err_to_d = 1'b0;
    end

    if (rx_byte_vld) begin
      // A strobe always wins over a timeout expiring in the same cycle
      to_cnt_d = '0;
      if (rx_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
        data_out_d = word_c;
        out_en_d   = 1'b1;
        rx_cnt_d   = 2'd0;
        shadow_d   = '0;
      end else begin
        shadow_d = word_c;
        rx_cnt_d = rx_cnt_q + 2'd1;
      end
    end else if (rx_cnt_q != 2'd0) begin
      if (to_inc == TO_W'(TIMEOUT_CYC)) begin
        rx_cnt_d = 2'd0;
        shadow_d = '0;
        to_cnt_d = '0;
        err_to_d = 1'b1;
      end else begin
        to_cnt_d = to_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_q   <= '0;
      shadow_q   <= '0;
      to_cnt_q   <= '0;
      data_out_q <= '0;
      out_en_q   <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      shadow_q   <= shadow_d;
      to_cnt_q   <= to_cnt_d;
      data_out_q <= data_out_d;
      out_en_q   <= out_en_d;
      err_to_q   <= err_to_d;
    end
  end

  assign UcUb_data_out    = data_out_q;
  assign UcUb_data_out_en = out_en_q;
  assign err_timeout      = err_to_q;

  // TX path is fully independent of RX
  uart_tx_serializer u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (UbUc_data_in),
    .data_in_en  (UbUc_data_in_en),
    .err_clr     (err_clr),
    .tx_byte     (tx_byte),
    .tx_byte_vld (tx_byte_vld),
    .tx_byte_rdy (tx_byte_rdy),
    .tx_busy     (tx_busy),
    .err_overrun (err_overrun)
  );

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: RX word table plus directed sequences for
// timeout, TX handshake, overrun, flag clearing, concurrency and reset.
module tb_uart_ctrl;

  localparam int unsigned T = 20;

`ifdef UART_CTRL_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_byte_vld;
  logic [7:0]  tx_byte;
  logic        tx_byte_vld;
  logic        tx_byte_rdy;
  logic [31:0] UcUb_data_out;
  logic        UcUb_data_out_en;
  logic [31:0] UbUc_data_in;
  logic        UbUc_data_in_en;
  logic        tx_busy;
  logic        err_timeout;
  logic        err_overrun;
  logic        err_clr;

  int total = 0;
  int bad   = 0;

  uart_ctrl #(.TIMEOUT_CYC(T), .TO_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_byte          (rx_byte),
    .rx_byte_vld      (rx_byte_vld),
    .tx_byte          (tx_byte),
    .tx_byte_vld      (tx_byte_vld),
    .tx_byte_rdy      (tx_byte_rdy),
    .UcUb_data_out    (UcUb_data_out),
    .UcUb_data_out_en (UcUb_data_out_en),
    .UbUc_data_in     (UbUc_data_in),
    .UbUc_data_in_en  (UbUc_data_in_en),
    .tx_busy          (tx_busy),
    .err_timeout      (err_timeout),
    .err_overrun      (err_overrun),
    .err_clr          (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] seq;      // bytes in wire order, first in [31:24]
    logic [31:0] exp_lsb;
    logic [31:0] exp_msb;
  } rx_vec_t;

  rx_vec_t vecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Four back-to-back strobes, then expect a single one-cycle pulse
  task automatic send_rx_word(input string nm, input logic [31:0] seq, input logic [31:0] exp);
    logic [31:0] s;
    s = seq;
    for (int i = 0; i < 4; i++) begin
      rx_byte     = s[31 - 8*i -: 8];
      rx_byte_vld = 1'b1;
      step();
    end
    rx_byte_vld = 1'b0;
    chk({nm, "_en"}, 32'(UcUb_data_out_en), 32'd1);
    chk({nm, "_data"}, UcUb_data_out, exp);
    step();
    chk({nm, "_en_low"}, 32'(UcUb_data_out_en), 32'd0);
    chk({nm, "_hold"}, UcUb_data_out, exp);
  endtask

  // Accept bytes with rdy held high for a bounded number of cycles
  task automatic tx_collect(output logic [31:0] rcv, output int n);
    rcv = '0;
    n   = 0;
    tx_byte_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (tx_byte_vld) begin
        rcv = {rcv[23:0], tx_byte};
        n++;
      end
      step();
      UbUc_data_in_en = 1'b0;
    end
    tx_byte_rdy = 1'b0;
  endtask

  logic [31:0] tx_seq;
  logic [31:0] rcv;
  int          n;
  logic        seen_en;

  initial begin
    vecs[0] = '{32'h11223344, 32'h44332211, 32'h11223344};
    vecs[1] = '{32'hAABBCCDD, 32'hDDCCBBAA, 32'hAABBCCDD};
    vecs[2] = '{32'h00FF0180, 32'h8001FF00, 32'h00FF0180};
    vecs[3] = '{32'h5AA53CC3, 32'hC33CA55A, 32'h5AA53CC3};

    rst_n = 1'b0; rx_byte = '0; rx_byte_vld = 1'b0; tx_byte_rdy = 1'b0;
    UbUc_data_in = '0; UbUc_data_in_en = 1'b0; err_clr = 1'b0;
    #12;
    chk("rst_data_out", UcUb_data_out, 32'd0);
    chk("rst_out_en", 32'(UcUb_data_out_en), 32'd0);
    chk("rst_tx_vld", 32'(tx_byte_vld), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_err_to", 32'(err_timeout), 32'd0);
    chk("rst_err_ov", 32'(err_overrun), 32'd0);
    rst_n = 1'b1;
    step();

    // RX word table
    foreach (vecs[i]) begin
      send_rx_word($sformatf("rx_vec%0d", i), vecs[i].seq, MSB ? vecs[i].exp_msb : vecs[i].exp_lsb);
    end

    // Partial word timeout: T-1 idle edges are tolerated, the T-th discards
    seen_en = 1'b0;
    rx_byte = 8'h01; rx_byte_vld = 1'b1; step();
    rx_byte = 8'h02; step();
    rx_byte_vld = 1'b0;
    for (int k = 1; k < int'(T); k++) begin
      step();
      seen_en |= UcUb_data_out_en;
    end
    chk("to_not_yet", 32'(err_timeout), 32'd0);
    step();
    seen_en |= UcUb_data_out_en;
    chk("to_fired", 32'(err_timeout), 32'd1);
    chk("to_no_pulse", 32'(seen_en), 32'd0);
    send_rx_word("to_recover", 32'hAABBCCDD, MSB ? 32'hAABBCCDD : 32'hDDCCBBAA);

    // TX with rdy toggling; bytes must hold while rdy is low
    tx_seq = MSB ? 32'hDEADBEEF : 32'hEFBEADDE;
    UbUc_data_in = 32'hDEADBEEF; UbUc_data_in_en = 1'b1;
    step();
    UbUc_data_in_en = 1'b0;
    chk("tx_busy_load", 32'(tx_busy), 32'd1);
    tx_byte_rdy = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tx_vld%0d", k), 32'(tx_byte_vld), 32'd1);
      chk($sformatf("tx_byte%0d", k), 32'(tx_byte), 32'(tx_seq[31 - 8*k -: 8]));
      step();
      chk($sformatf("tx_hold%0d", k), 32'(tx_byte), 32'(tx_seq[31 - 8*k -: 8]));
      chk($sformatf("tx_hold_vld%0d", k), 32'(tx_byte_vld), 32'd1);
      tx_byte_rdy = 1'b1;
      step();
      tx_byte_rdy = 1'b0;
    end
    chk("tx_done_vld", 32'(tx_byte_vld), 32'd0);
    chk("tx_done_busy", 32'(tx_busy), 32'd1);
    step();
    chk("tx_idle_busy", 32'(tx_busy), 32'd0);

    // Overrun: second word during SEND is dropped, first word intact
    UbUc_data_in = 32'h01020304; UbUc_data_in_en = 1'b1;
    step();
    UbUc_data_in_en = 1'b0; tx_byte_rdy = 1'b1;
    step();
    UbUc_data_in = 32'hFFFFFFFF; UbUc_data_in_en = 1'b1;
    tx_collect(rcv, n);
    chk("ovr_flag", 32'(err_overrun), 32'd1);
    chk("ovr_nbytes", 32'(n), 32'd4);
    chk("ovr_word", rcv, MSB ? 32'h01020304 : 32'h04030201);
    chk("ovr_idle", 32'(tx_busy), 32'd0);

    // Both flags set here; clear them together
    chk("pre_clr_to", 32'(err_timeout), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("clr_to", 32'(err_timeout), 32'd0);
    chk("clr_ov", 32'(err_overrun), 32'd0);

    // Strobe on the expiring cycle is accepted, no timeout
    rx_byte = 8'h10; rx_byte_vld = 1'b1; step();
    rx_byte_vld = 1'b0;
    for (int k = 1; k < int'(T); k++) step();
    rx_byte = 8'h20; rx_byte_vld = 1'b1; step();
    rx_byte = 8'h30; step();
    rx_byte = 8'h40; step();
    rx_byte_vld = 1'b0;
    chk("win_en", 32'(UcUb_data_out_en), 32'd1);
    chk("win_data", UcUb_data_out, MSB ? 32'h10203040 : 32'h40302010);
    chk("win_no_to", 32'(err_timeout), 32'd0);
    step();

    // Overrun set and err_clr in the same cycle: set wins
    UbUc_data_in = 32'h11111111; UbUc_data_in_en = 1'b1; step();
    UbUc_data_in_en = 1'b0; step();
    UbUc_data_in_en = 1'b1; err_clr = 1'b1; step();
    UbUc_data_in_en = 1'b0; err_clr = 1'b0;
    chk("setwins_ov", 32'(err_overrun), 32'd1);
    tx_collect(rcv, n);
    chk("setwins_word", rcv, 32'h11111111);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("setwins_clr", 32'(err_overrun), 32'd0);

    // 4th RX strobe and TX start in the same cycle
    rx_byte_vld = 1'b1;
    rx_byte = 8'hA1; step();
    rx_byte = 8'hB2; step();
    rx_byte = 8'hC3; step();
    rx_byte = 8'hD4; UbUc_data_in = 32'hCAFEF00D; UbUc_data_in_en = 1'b1; step();
    rx_byte_vld = 1'b0; UbUc_data_in_en = 1'b0;
    chk("sim_rx_en", 32'(UcUb_data_out_en), 32'd1);
    chk("sim_rx_data", UcUb_data_out, MSB ? 32'hA1B2C3D4 : 32'hD4C3B2A1);
    chk("sim_tx_busy", 32'(tx_busy), 32'd1);
    tx_collect(rcv, n);
    chk("sim_nbytes", 32'(n), 32'd4);
    chk("sim_tx_word", rcv, MSB ? 32'hCAFEF00D : 32'h0DF0FECA);
    chk("sim_no_ovr", 32'(err_overrun), 32'd0);

    // Reset mid-word and mid-send
    rx_byte_vld = 1'b1;
    rx_byte = 8'h99; step();
    rx_byte = 8'h88; step();
    rx_byte_vld = 1'b0;
    UbUc_data_in = 32'h12345678; UbUc_data_in_en = 1'b1; step();
    UbUc_data_in_en = 1'b0; tx_byte_rdy = 1'b1; step();
    step();
    tx_byte_rdy = 1'b0;
    chk("mid_tx_vld", 32'(tx_byte_vld), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_data_out", UcUb_data_out, 32'd0);
    chk("ar_tx_vld", 32'(tx_byte_vld), 32'd0);
    chk("ar_tx_byte", 32'(tx_byte), 32'd0);
    chk("ar_busy", 32'(tx_busy), 32'd0);
    chk("ar_out_en", 32'(UcUb_data_out_en), 32'd0);
    rst_n = 1'b1;
    send_rx_word("post_rst", 32'h01020304, MSB ? 32'h01020304 : 32'h04030201);
    chk("post_rst_busy", 32'(tx_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
